agc_att_ctrl: RTL and testbench
===============================

// Module: agc_att_ctrl
// PURPOSE
//  Closed-loop AGC stage directly downstream of the signed peak detector.
//  Consumes the per-measurement-period peak magnitude and steps an attenuator code so the peak stays in a target window.
//  A settle hold-off ignores peaks measured while the attenuator is still responding.
//  att_code drives the front-end digital step attenuator; a manual override bypasses the loop.
// PARAMETERS
//  IN_W        16        width of peak magnitude input (unsigned, MSB always 0 from detector)
//  ATT_W       6         width of attenuator code
//  ATT_MAX     63        highest legal attenuator code (max attenuation)
//  ATT_INIT    0         att_code value after reset
//  HI_THRESH   24000     peak > HI_THRESH -> increase attenuation
//  LO_THRESH   12000     peak < LO_THRESH -> decrease attenuation (LO_THRESH < HI_THRESH)
//  STEP        1         normal attenuation step per decision
//  SETTLE_PER  2         measurement periods skipped after each code change (>=1)
//  OVL_THRESH  32000     fast-attack threshold (used only with AGC_FAST_ATTACK_EN)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, ACTIVE-LOW
//  max_in      in   IN_W   peak magnitude of last completed period
//  max_stb     in   1      1-cycle strobe: max_in valid/new this cycle
//  agc_en      in   1      1 = closed loop, 0 = manual
//  manual_att  in   ATT_W  code driven when agc_en = 0
//  att_code    out  ATT_W  attenuator code (registered)
//  att_valid   out  1      1-cycle pulse each cycle att_code changes value
//  too_high    out  1      last evaluated peak > HI_THRESH
//  too_low     out  1      last evaluated peak < LO_THRESH
//  at_limit    out  1      att_code == 0 or == ATT_MAX
//  ovl         out  1      last evaluated peak >= OVL_THRESH (0 without macro)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, att_code=ATT_INIT, att_valid/too_high/too_low/ovl=0, settle_cnt=0; at_limit from ATT_INIT.
//  FSM states: IDLE, TRACK, EVAL, SETTLE.
//  IDLE: att_code <= manual_att each cycle (1-cycle latency); att_valid pulses when value changes. agc_en=1 -> TRACK,
//    loop starts from current att_code.
//  TRACK: on max_stb, latch max_in into max_lat -> EVAL.
//  EVAL (1 cycle): compare max_lat (unsigned, IN_W bits):
//    > HI_THRESH: att_code <= min(att_code+STEP, ATT_MAX); too_high=1.
//    < LO_THRESH: att_code <= max(att_code-STEP, 0); too_low=1.
//    else: no change, both flags 0 -> TRACK.
//    If the code actually changed: att_valid=1 for that cycle, settle_cnt=0 -> SETTLE.
//    If clamped at a limit (no change): no att_valid -> TRACK.
//  Saturating arithmetic: compute in ATT_W+1 bits, clamp before assignment; never wrap.
//  SETTLE: each max_stb increments settle_cnt, its max_in is discarded;
//    on the SETTLE_PER-th strobe -> TRACK (next strobe is evaluated).
//  Latency: max_stb at cycle n -> EVAL at n+1 -> att_code/att_valid updated at n+2.
//  agc_en -> 0 in any state: next cycle state=IDLE, att_code <= manual_att, pending EVAL/SETTLE dropped.
//  max_stb while in EVAL: ignored (strobes are >= 1 ms apart in normal use).
//  max_stb while in IDLE: ignored.
//  Flags hold until the next EVAL; they clear on entry to IDLE.
//  Reset asserted mid-operation: immediate return to reset values; no partial update.
// CONFIGURATION
//  AGC_FAST_ATTACK_EN defined: in EVAL, max_lat >= OVL_THRESH -> step is 4*STEP (saturating at ATT_MAX);
//    ovl=1 for that decision; otherwise normal rules apply.
//  Not defined: OVL_THRESH unused, ovl tied 0, every increase uses STEP.
// TESTING
//  1. Reset with ATT_INIT=0, agc_en=1, max_in=30000 strobe -> att_code=1 two cycles later, att_valid 1 cycle, too_high=1.
//  2. After (1): next 2 strobes at 30000 ignored (SETTLE_PER=2) -> third strobe -> att_code=2.
//  3. att_code=5, max_in=5000 strobe -> att_code=4, too_low=1; max_in=18000 -> no change, no att_valid, flags 0.
//  4. att_code=63, max_in=30000 -> stays 63, at_limit=1, no att_valid, state back to TRACK (next strobe evaluated).
//  5. agc_en 1->0 during SETTLE, manual_att=17 -> att_code=17 next cycle, att_valid pulse; strobes ignored.
//  6. AGC_FAST_ATTACK_EN, att_code=10, max_in=32767 -> att_code=14, ovl=1; macro off -> att_code=11, ovl=0.

Source files
------------

// File: rtl/agc_att_ctrl.sv
// rtl/agc_att_ctrl.sv - closed-loop AGC attenuator code controller
//
// Steps a digital step attenuator code so the measured peak magnitude stays
// inside [LO_THRESH, HI_THRESH]. After each code change, SETTLE_PER measurement
// strobes are discarded while the analog front end settles. When agc_en is low
// the loop is bypassed and manual_att drives att_code.
//
// Optional feature macro: AGC_FAST_ATTACK_EN
//   Defined     : peaks >= OVL_THRESH step by 4*STEP and raise ovl.
//   Not defined : every increase uses STEP, ovl is tied 0.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   max_in      in   peak magnitude of last completed period (unsigned)
//   max_stb     in   one-cycle strobe, max_in is new this cycle
//   agc_en      in   1 = closed loop, 0 = manual
//   manual_att  in   code driven while agc_en = 0
//   att_code    out  registered attenuator code
//   att_valid   out  one-cycle pulse whenever att_code changes value
//   too_high    out  last evaluated peak > HI_THRESH
//   too_low     out  last evaluated peak < LO_THRESH
//   at_limit    out  att_code is 0 or ATT_MAX
//   ovl         out  last evaluated peak >= OVL_THRESH (fast attack only)

module agc_att_ctrl #(
  parameter int IN_W       = 16,
  parameter int ATT_W      = 6,
  parameter int ATT_MAX    = 63,
  parameter int ATT_INIT   = 0,
  parameter int HI_THRESH  = 24000,
  parameter int LO_THRESH  = 12000,
  parameter int STEP       = 1,
  parameter int SETTLE_PER = 2,
  parameter int OVL_THRESH = 32000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  max_in,
  input  logic             max_stb,
  input  logic             agc_en,
  input  logic [ATT_W-1:0] manual_att,
  output logic [ATT_W-1:0] att_code,
  output logic             att_valid,
  output logic             too_high,
  output logic             too_low,
  output logic             at_limit,
  output logic             ovl
);

  localparam int AW1   = ATT_W + 1;
  localparam int CNT_W = $clog2(SETTLE_PER + 1);

  localparam logic [IN_W-1:0]  HI_T      = IN_W'(HI_THRESH);
  localparam logic [IN_W-1:0]  LO_T      = IN_W'(LO_THRESH);
  localparam logic [AW1-1:0]   ATT_MAX_W = AW1'(ATT_MAX);
  localparam logic [AW1-1:0]   STEP1_W   = AW1'(STEP);
  localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_PER);

`ifdef AGC_FAST_ATTACK_EN
  localparam logic [IN_W-1:0]  OVL_T   = IN_W'(OVL_THRESH);
  localparam logic [AW1-1:0]   STEP4_W = AW1'(4 * STEP);
`else
  logic unused_ovl_thresh;
  assign unused_ovl_thresh = (OVL_THRESH != 0);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    EVAL   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic              valid_q, valid_d;
  logic              high_q, high_d;
  logic              low_q, low_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   lat_q, lat_d;

  // Decision datapath, evaluated from the latched peak
  logic              gt, lt, fast;
  logic [AW1-1:0]    att_w, step_w, inc_w, inc_sat, dec_sat, new_w;

  always_comb begin
    gt  = lat_q > HI_T;
    lt  = lat_q < LO_T;
`ifdef AGC_FAST_ATTACK_EN
    fast = lat_q >= OVL_T;
`else
    fast = 1'b0;
`endif
    att_w  = {1'b0, att_q};
`ifdef AGC_FAST_ATTACK_EN
    step_w = fast ? STEP4_W : STEP1_W;
`else
    step_w = STEP1_W;
`endif
    // One extra bit of headroom so the sum cannot wrap before the clamp
    inc_w   = att_w + step_w;
    inc_sat = (inc_w > ATT_MAX_W) ? ATT_MAX_W : inc_w;
    dec_sat = (att_w < STEP1_W) ? '0 : (att_w - STEP1_W);
    if (gt) begin
      new_w = inc_sat;
    end else if (lt) begin
      new_w = dec_sat;
    end else begin
      new_w = att_w;
    end
  end

  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    valid_d = 1'b0;
    high_d  = high_q;
    low_d   = low_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;

    if (!agc_en) begin
      // Manual mode wins from any state; pending decisions are dropped
      state_d = IDLE;
      att_d   = manual_att;
      valid_d = (manual_att != att_q);
      high_d  = 1'b0;
      low_d   = 1'b0;
      ovl_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Loop resumes from whatever code manual mode left behind
          state_d = TRACK;
        end
        TRACK: begin
          if (max_stb) begin
            lat_d   = max_in;
            state_d = EVAL;
          end
        end
        EVAL: begin
          high_d = gt;
          low_d  = lt;
          ovl_d  = fast;
          if (new_w != att_w) begin
            att_d   = new_w[ATT_W-1:0];
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            state_d = TRACK;
          end
        end
        SETTLE: begin
          if (max_stb) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == SETTLE_N) begin
              state_d = TRACK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      att_q   <= ATT_W'(ATT_INIT);
      valid_q <= 1'b0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
      ovl_q   <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      valid_q <= valid_d;
      high_q  <= high_d;
      low_q   <= low_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  assign att_code  = att_q;
  assign att_valid = valid_q;
  assign too_high  = high_q;
  assign too_low   = low_q;
  assign ovl       = ovl_q;
  assign at_limit  = (att_q == '0) || (att_q == ATT_W'(ATT_MAX));

endmodule

// File: tb/tb_agc_att_ctrl.sv
// tb/tb_agc_att_ctrl.sv - directed self-checking bench for agc_att_ctrl

module tb_agc_att_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] max_in;
  logic        max_stb;
  logic        agc_en;
  logic [5:0]  manual_att;
  logic [5:0]  att_code;
  logic        att_valid;
  logic        too_high;
  logic        too_low;
  logic        at_limit;
  logic        ovl;

  int n_chk  = 0;
  int n_fail = 0;

  agc_att_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .max_in     (max_in),
    .max_stb    (max_stb),
    .agc_en     (agc_en),
    .manual_att (manual_att),
    .att_code   (att_code),
    .att_valid  (att_valid),
    .too_high   (too_high),
    .too_low    (too_low),
    .at_limit   (at_limit),
    .ovl        (ovl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one peak for exactly one sampling edge
  task automatic strobe(input logic [15:0] v);
    max_in  = v;
    max_stb = 1'b1;
    tick();
    max_stb = 1'b0;
  endtask

  // Load a code through manual mode, then close the loop again
  task automatic preload(input logic [5:0] code);
    agc_en     = 1'b0;
    manual_att = code;
    tick();
    agc_en = 1'b1;
    tick();
  endtask

`ifdef AGC_FAST_ATTACK_EN
  localparam logic [5:0] FA_CODE = 6'd14;
  localparam logic       FA_OVL  = 1'b1;
`else
  localparam logic [5:0] FA_CODE = 6'd11;
  localparam logic       FA_OVL  = 1'b0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    agc_en     = 1'b1;
    max_in     = '0;
    max_stb    = 1'b0;
    manual_att = '0;
    tick();
    tick();
    check_eq("rst_att",      att_code,  0);
    check_eq("rst_valid",    att_valid, 0);
    check_eq("rst_high",     too_high,  0);
    check_eq("rst_low",      too_low,   0);
    check_eq("rst_ovl",      ovl,       0);
    check_eq("rst_at_limit", at_limit,  1);
    rst = 1'b1;
    tick();                                  // IDLE -> TRACK

    // 1: high peak raises code by one, two cycles after strobe
    strobe(16'd30000);
    check_eq("t1_no_early", att_code, 0);
    tick();
    check_eq("t1_att",   att_code,  1);
    check_eq("t1_valid", att_valid, 1);
    check_eq("t1_high",  too_high,  1);
    check_eq("t1_low",   too_low,   0);
    tick();
    check_eq("t1_valid_pulse", att_valid, 0);

    // 2: two strobes discarded while settling, third is evaluated
    strobe(16'd30000); tick();
    check_eq("t2_settle1", att_code, 1);
    strobe(16'd30000); tick();
    check_eq("t2_settle2", att_code, 1);
    strobe(16'd30000); tick();
    check_eq("t2_att",   att_code,  2);
    check_eq("t2_valid", att_valid, 1);

    // 3: low peak lowers code; in-window peak leaves it alone
    agc_en     = 1'b0;
    manual_att = 6'd5;
    tick();
    check_eq("man5_att",   att_code,  5);
    check_eq("man5_valid", att_valid, 1);
    check_eq("man5_clr",   too_high,  0);
    agc_en = 1'b1;
    tick();
    strobe(16'd5000); tick();
    check_eq("t3_att",   att_code, 4);
    check_eq("t3_low",   too_low,  1);
    check_eq("t3_high",  too_high, 0);
    strobe(16'd18000); tick();
    strobe(16'd18000); tick();
    strobe(16'd18000); tick();
    check_eq("t3_hold_att",   att_code,  4);
    check_eq("t3_hold_valid", att_valid, 0);
    check_eq("t3_hold_low",   too_low,   0);
    check_eq("t3_hold_high",  too_high,  0);

    // Threshold boundaries: equal to a threshold is inside the window
    strobe(16'd24000); tick();
    check_eq("b_hi_eq", att_code, 4);
    strobe(16'd12000); tick();
    check_eq("b_lo_eq", att_code, 4);
    check_eq("b_lo_eq_flag", too_low, 0);
    strobe(16'd24001); tick();
    check_eq("b_hi_plus1", att_code, 5);
    check_eq("b_hi_plus1_flag", too_high, 1);

    // 4: clamp at ATT_MAX, no pulse, next strobe evaluated at once
    preload(6'd63);
    check_eq("t4_limit", at_limit, 1);
    strobe(16'd30000); tick();
    check_eq("t4_att",   att_code,  63);
    check_eq("t4_valid", att_valid, 0);
    check_eq("t4_high",  too_high,  1);
    tick();
    strobe(16'd5000); tick();
    check_eq("t4_track_att", att_code,  62);
    check_eq("t4_track_vld", att_valid, 1);
    check_eq("t4_nolimit",   at_limit,  0);

    // 5: drop to manual while settling
    agc_en     = 1'b0;
    manual_att = 6'd17;
    tick();
    check_eq("t5_att",   att_code,  17);
    check_eq("t5_valid", att_valid, 1);
    check_eq("t5_low",   too_low,   0);
    tick();
    check_eq("t5_pulse", att_valid, 0);
    strobe(16'd30000); tick();
    check_eq("t5_ign_att",  att_code, 17);
    check_eq("t5_ign_high", too_high, 0);

    // Lower clamp at 0
    preload(6'd0);
    strobe(16'd5000); tick();
    check_eq("lo_clamp_att",   att_code,  0);
    check_eq("lo_clamp_valid", att_valid, 0);
    check_eq("lo_clamp_low",   too_low,   1);

    // 6: overload peak, behaviour depends on fast-attack build
    preload(6'd10);
    strobe(16'd32767); tick();
    check_eq("t6_att", att_code, FA_CODE);
    check_eq("t6_ovl", ovl,      FA_OVL);

    // Reset mid-decision returns to reset values immediately
    tick(); tick(); tick();
    strobe(16'd5000); tick();
    strobe(16'd5000); tick();
    strobe(16'd30000);                       // now in EVAL
    rst = 1'b0;
    #1;
    check_eq("mid_rst_att",   att_code,  0);
    check_eq("mid_rst_high",  too_high,  0);
    check_eq("mid_rst_valid", att_valid, 0);
    tick();
    check_eq("mid_rst_hold", att_code, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
